// File: rtl/fpu_pkg.sv
// Shared FPU constants, rounding-mode encodings and the rounding-increment helper.
package fpu_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_W   = 24;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned INT_W    = 32;
    localparam int unsigned MAG_W    = INT_W + 1;
    localparam int unsigned CNT_W    = 5;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    localparam logic [INT_W-1:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [INT_W-1:0] UINT_MAX = 32'hFFFF_FFFF;

    // Exponent thresholds: |x|<0.5, integer-aligned mantissa, |x|>=2^32
    localparam logic [EXP_W-1:0] EXP_HALF  = EXP_W'(EXP_BIAS - 1);
    localparam logic [EXP_W-1:0] EXP_ALIGN = EXP_W'(EXP_BIAS + FRAC_W);
    localparam logic [EXP_W-1:0] EXP_OVF   = EXP_W'(EXP_BIAS + INT_W);
    localparam logic [EXP_W-1:0] EXP_ALL1  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } f2i_state_e;

    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic st);
        logic inc;
        inc = 1'b0;
        case (rm)
            RNE:     inc = g & (st | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = (g | st) & sign;
            RUP:     inc = (g | st) & ~sign;
            RMM:     inc = g;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fcvt_align_shifter.sv
// Iterative alignment shifter: holds the magnitude and collects guard/sticky on right shifts.
module fcvt_align_shifter
    import fpu_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [MAG_W-1:0] load_mag,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             load_left,
    input  logic             load_st,
    input  logic             step,
    output logic [MAG_W-1:0] mag,
    output logic             g,
    output logic             st,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt;
    logic             left;
    logic [MAG_W-1:0] mag_n;
    logic             g_n;
    logic             st_n;
    logic [CNT_W-1:0] cnt_n;

    // Up to SHIFT_PER_CYCLE single-bit steps, stopping when the count runs out
    always_comb begin
        mag_n = mag;
        g_n   = g;
        st_n  = st;
        cnt_n = cnt;
        for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (cnt_n != '0) begin
                if (left) begin
                    mag_n = {mag_n[MAG_W-2:0], 1'b0};
                end else begin
                    st_n  = st_n | g_n;
                    g_n   = mag_n[0];
                    mag_n = {1'b0, mag_n[MAG_W-1:1]};
                end
                cnt_n = cnt_n - CNT_W'(1);
            end
        end
    end

    assign last_c = (cnt <= CNT_W'(SHIFT_PER_CYCLE));

    always_ff @(posedge clock) begin
        if (!reset) begin
            mag  <= '0;
            g    <= 1'b0;
            st   <= 1'b0;
            cnt  <= '0;
            left <= 1'b0;
        end else if (load) begin
            mag  <= load_mag;
            g    <= 1'b0;
            st   <= load_st;
            cnt  <= load_cnt;
            left <= load_left;
        end else if (step) begin
            mag  <= mag_n;
            g    <= g_n;
            st   <= st_n;
            cnt  <= cnt_n;
        end
    end

endmodule

// File: rtl/fcvt_f2i.sv
// FCVT.W.S / FCVT.WU.S: multi-cycle float-to-integer converter with valid/ready on both sides.
module fcvt_f2i
    import fpu_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [INT_W-1:0] io_input1,
    input  logic             io_unsigned,
    input  logic [2:0]       io_rmm,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [INT_W-1:0] io_result,
    output logic             io_flag_nv,
    output logic             io_flag_nx,
    output logic             io_illegal_rm
);

    f2i_state_e state_q, state_d;

    logic              sign_q, uns_q, special_q, nan_q;
    logic [2:0]        rm_q;

    logic [EXP_W-1:0]  op_exp;
    logic [FRAC_W-1:0] op_frac;
    logic [MANT_W-1:0] op_mant;

    logic              sh_load, sh_step, sh_left, sh_st, sh_last;
    logic [MAG_W-1:0]  sh_mag_in, mag;
    logic [CNT_W-1:0]  sh_cnt;
    logic              g, st;

    logic              lat_en, sp_d, out_upd, nv_d, nx_d, ill_d;
    logic [INT_W-1:0]  res_d;

    logic              inc;
    logic [MAG_W-1:0]  mag_r;
    logic [INT_W-1:0]  rnd_res;
    logic              rnd_nv, rnd_nx;

    assign op_exp  = io_input1[30:23];
    assign op_frac = io_input1[22:0];
    assign op_mant = {op_exp != '0, op_frac};

    fcvt_align_shifter #(
        .SHIFT_PER_CYCLE(SHIFT_PER_CYCLE)
    ) u_shift (
        .clock    (clock),
        .reset    (reset),
        .load     (sh_load),
        .load_mag (sh_mag_in),
        .load_cnt (sh_cnt),
        .load_left(sh_left),
        .load_st  (sh_st),
        .step     (sh_step),
        .mag      (mag),
        .g        (g),
        .st       (st),
        .last_c   (sh_last)
    );

    // Round the aligned magnitude, then saturate against the target integer range
    always_comb begin
        inc     = round_inc(rm_q, sign_q, mag[0], g, st);
        mag_r   = mag + MAG_W'(inc);
        rnd_res = '0;
        rnd_nv  = 1'b0;
        if (special_q) begin
            rnd_nv = 1'b1;
            if (nan_q || !sign_q) rnd_res = uns_q ? UINT_MAX : INT_MAX;
            else                  rnd_res = uns_q ? '0 : INT_MIN;
        end else if (uns_q) begin
            if (sign_q) begin
                rnd_nv = (mag_r != '0);
            end else if (mag_r[INT_W]) begin
                rnd_nv  = 1'b1;
                rnd_res = UINT_MAX;
            end else begin
                rnd_res = mag_r[INT_W-1:0];
            end
        end else if (!sign_q) begin
            if (mag_r > MAG_W'(INT_MAX)) begin
                rnd_nv  = 1'b1;
                rnd_res = INT_MAX;
            end else begin
                rnd_res = mag_r[INT_W-1:0];
            end
        end else begin
            if (mag_r > MAG_W'(INT_MIN)) begin
                rnd_nv  = 1'b1;
                rnd_res = INT_MIN;
            end else begin
                rnd_res = ~mag_r[INT_W-1:0] + INT_W'(1);
            end
        end
        rnd_nx = (g | st) & ~rnd_nv;
    end

    // Next-state and datapath controls
    always_comb begin
        state_d   = state_q;
        sh_load   = 1'b0;
        sh_step   = 1'b0;
        sh_mag_in = '0;
        sh_cnt    = '0;
        sh_left   = 1'b0;
        sh_st     = 1'b0;
        lat_en    = 1'b0;
        sp_d      = 1'b0;
        out_upd   = 1'b0;
        res_d     = '0;
        nv_d      = 1'b0;
        nx_d      = 1'b0;
        ill_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_in_valid) begin
                    lat_en  = 1'b1;
                    sh_load = 1'b1;
                    if (io_rmm > RMM) begin
                        out_upd = 1'b1;
                        ill_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_exp >= EXP_OVF) begin
                        sp_d    = 1'b1;
                        state_d = ST_ROUND;
                    end else if (op_exp >= EXP_ALIGN) begin
                        sh_mag_in = MAG_W'(op_mant);
                        sh_cnt    = CNT_W'(op_exp - EXP_ALIGN);
                        sh_left   = 1'b1;
                        state_d   = (sh_cnt == '0) ? ST_ROUND : ST_SHIFT;
                    end else if (op_exp >= EXP_HALF) begin
                        sh_mag_in = MAG_W'(op_mant);
                        sh_cnt    = CNT_W'(EXP_ALIGN - op_exp);
                        state_d   = ST_SHIFT;
                    end else begin
                        sh_st   = (io_input1[30:0] != '0);
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_SHIFT: begin
                sh_step = 1'b1;
                if (sh_last) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                out_upd = 1'b1;
                res_d   = rnd_res;
                nv_d    = rnd_nv;
                nx_d    = rnd_nx;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            io_in_ready   <= 1'b1;
            io_out_valid  <= 1'b0;
            io_result     <= '0;
            io_flag_nv    <= 1'b0;
            io_flag_nx    <= 1'b0;
            io_illegal_rm <= 1'b0;
            sign_q        <= 1'b0;
            uns_q         <= 1'b0;
            rm_q          <= '0;
            special_q     <= 1'b0;
            nan_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            io_in_ready  <= (state_d == ST_IDLE);
            io_out_valid <= (state_d == ST_DONE);
            if (lat_en) begin
                sign_q    <= io_input1[31];
                uns_q     <= io_unsigned;
                rm_q      <= io_rmm;
                special_q <= sp_d;
                nan_q     <= (op_exp == EXP_ALL1) && (op_frac != '0);
            end
            if (out_upd) begin
                io_result     <= res_d;
                io_flag_nv    <= nv_d;
                io_flag_nx    <= nx_d;
                io_illegal_rm <= ill_d;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_f2i.sv
// Self-checking bench for fcvt_f2i: directed table, handshake/reset sequences, random vs. arithmetic model.
module tb_fcvt_f2i;

    localparam int unsigned SPC = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_input1;
    logic        io_unsigned;
    logic [2:0]  io_rmm;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_result;
    logic        io_flag_nv;
    logic        io_flag_nx;
    logic        io_illegal_rm;

    int n_cmp = 0;
    int n_bad = 0;

    fcvt_f2i #(.SHIFT_PER_CYCLE(SPC)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_input1    (io_input1),
        .io_unsigned  (io_unsigned),
        .io_rmm       (io_rmm),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_result    (io_result),
        .io_flag_nv   (io_flag_nv),
        .io_flag_nx   (io_flag_nx),
        .io_illegal_rm(io_illegal_rm)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] op;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        nv;
        logic        nx;
        logic        ill;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact value m*2^(e-150), rounded by comparing the discarded remainder to one half
    function automatic void ref_model(input logic [31:0] op, input logic uns, input logic [2:0] rm,
                                      output logic [31:0] res, output logic nv, output logic nx,
                                      output logic ill, output int lat);
        int     e;
        int     k;
        int     n;
        bit     s;
        bit     pos;
        bit     up;
        bit     inexact;
        longint m, q, rem, half, v, lo, hi, one;
        e = int'(op[30:23]);
        s = op[31];
        one = 1;
        res = 32'h0; nv = 1'b0; nx = 1'b0; ill = 1'b0; lat = 0;
        if (rm > 3'd4) begin
            ill = 1'b1;
            lat = 1;
            return;
        end
        if (e >= 159) begin
            nv  = 1'b1;
            lat = 2;
            pos = ((e == 255) && (op[22:0] != 0)) || !s;
            if (uns) res = pos ? 32'hFFFFFFFF : 32'h0;
            else     res = pos ? 32'h7FFFFFFF : 32'h80000000;
            return;
        end
        m = longint'(op[22:0]);
        if (e != 0) m = m + (one << 23);
        if (e >= 150) begin
            n    = e - 150;
            q    = m << n;
            rem  = 0;
            half = 1;
            lat  = (n + int'(SPC) - 1) / int'(SPC) + 2;
        end else begin
            k = 150 - e;
            lat = (e >= 126) ? (k + int'(SPC) - 1) / int'(SPC) + 2 : 2;
            if (k > 40) k = 40;
            q    = m >> k;
            rem  = m & ((one << k) - 1);
            half = one << (k - 1);
        end
        inexact = (rem != 0);
        case (rm)
            3'd0:    up = (rem > half) || ((rem == half) && ((q % 2) == 1));
            3'd2:    up = inexact && s;
            3'd3:    up = inexact && !s;
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
        endcase
        q = q + (up ? 1 : 0);
        v = s ? -q : q;
        if (uns) begin lo = 0;             hi = (one << 32) - 1; end
        else     begin lo = -(one << 31);  hi = (one << 31) - 1; end
        if (v < lo) begin
            nv  = 1'b1;
            res = uns ? 32'h0 : 32'h80000000;
        end else if (v > hi) begin
            nv  = 1'b1;
            res = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
        end else begin
            res = v[31:0];
        end
        nx = inexact && !nv;
    endfunction

    task automatic convert(input logic [31:0] op, input logic uns, input logic [2:0] rm,
                           output logic [31:0] res, output logic nv, output logic nx,
                           output logic ill, output int lat);
        int n;
        n = 0;
        while (!io_in_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        io_input1   = op;
        io_unsigned = uns;
        io_rmm      = rm;
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        lat = 1;
        while (!io_out_valid && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        res = io_result;
        nv  = io_flag_nv;
        nx  = io_flag_nx;
        ill = io_illegal_rm;
    endtask

    task automatic run_case(input string tag, input logic [31:0] op, input logic uns,
                            input logic [2:0] rm, input logic [31:0] e_res, input logic e_nv,
                            input logic e_nx, input logic e_ill, input int e_lat);
        logic [31:0] res;
        logic        nv, nx, ill;
        int          lat;
        convert(op, uns, rm, res, nv, nx, ill, lat);
        check({tag, " result"}, res, e_res);
        check({tag, " nv"}, 32'(nv), 32'(e_nv));
        check({tag, " nx"}, 32'(nx), 32'(e_nx));
        check({tag, " illegal_rm"}, 32'(ill), 32'(e_ill));
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
    endtask

    initial begin
        logic [31:0] m_res;
        logic        m_nv, m_nx, m_ill;
        int          m_lat;
        int          n;
        logic [31:0] op;
        logic [2:0]  rm;
        logic        uns;
        int          r;

        tbl[0]  = '{32'h40490FDB, 1'b0, 3'd0, 32'd3,          1'b0, 1'b1, 1'b0};
        tbl[1]  = '{32'h3FC00000, 1'b0, 3'd0, 32'd2,          1'b0, 1'b1, 1'b0};
        tbl[2]  = '{32'h3FC00000, 1'b0, 3'd1, 32'd1,          1'b0, 1'b1, 1'b0};
        tbl[3]  = '{32'h3FC00000, 1'b0, 3'd2, 32'd1,          1'b0, 1'b1, 1'b0};
        tbl[4]  = '{32'h3FC00000, 1'b0, 3'd3, 32'd2,          1'b0, 1'b1, 1'b0};
        tbl[5]  = '{32'h3FC00000, 1'b0, 3'd4, 32'd2,          1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'h40200000, 1'b0, 3'd0, 32'd2,          1'b0, 1'b1, 1'b0};
        tbl[7]  = '{32'h40200000, 1'b0, 3'd4, 32'd3,          1'b0, 1'b1, 1'b0};
        tbl[8]  = '{32'hC0200000, 1'b0, 3'd2, 32'hFFFFFFFD,   1'b0, 1'b1, 1'b0};
        tbl[9]  = '{32'hC0200000, 1'b0, 3'd3, 32'hFFFFFFFE,   1'b0, 1'b1, 1'b0};
        tbl[10] = '{32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF,   1'b1, 1'b0, 1'b0};
        tbl[11] = '{32'h4F000000, 1'b1, 3'd0, 32'h80000000,   1'b0, 1'b0, 1'b0};
        tbl[12] = '{32'hCF000000, 1'b0, 3'd0, 32'h80000000,   1'b0, 1'b0, 1'b0};
        tbl[13] = '{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF,   1'b1, 1'b0, 1'b0};
        tbl[14] = '{32'hFF800000, 1'b1, 3'd0, 32'h00000000,   1'b1, 1'b0, 1'b0};
        tbl[15] = '{32'h00000000, 1'b0, 3'd0, 32'h00000000,   1'b0, 1'b0, 1'b0};
        tbl[16] = '{32'hBE99999A, 1'b1, 3'd1, 32'h00000000,   1'b0, 1'b1, 1'b0};
        tbl[17] = '{32'h3FC00000, 1'b0, 3'd5, 32'h00000000,   1'b0, 1'b0, 1'b1};
        tbl[18] = '{32'h4B000000, 1'b0, 3'd1, 32'h00800000,   1'b0, 1'b0, 1'b0};
        tbl[19] = '{32'hBF800000, 1'b1, 3'd0, 32'h00000000,   1'b1, 1'b0, 1'b0};
        tbl[20] = '{32'h4F800000, 1'b1, 3'd1, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b0};
        tbl[21] = '{32'h3F000000, 1'b0, 3'd0, 32'h00000000,   1'b0, 1'b1, 1'b0};
        tbl[22] = '{32'h3F000000, 1'b0, 3'd4, 32'h00000001,   1'b0, 1'b1, 1'b0};

        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_input1    = 32'h0;
        io_unsigned  = 1'b0;
        io_rmm       = 3'd0;
        io_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset out_valid", 32'(io_out_valid), 32'd0);
        check("reset in_ready", 32'(io_in_ready), 32'd1);
        check("reset result", io_result, 32'h0);
        check("reset flags", 32'({io_flag_nv, io_flag_nx, io_illegal_rm}), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed vectors; latency comes from the cycle-count formula in the model
        for (int i = 0; i < 23; i++) begin
            ref_model(tbl[i].op, tbl[i].uns, tbl[i].rm, m_res, m_nv, m_nx, m_ill, m_lat);
            run_case($sformatf("vec%0d", i), tbl[i].op, tbl[i].uns, tbl[i].rm,
                     tbl[i].res, tbl[i].nv, tbl[i].nx, tbl[i].ill, m_lat);
        end

        // Result must hold while the consumer stalls
        n = 0;
        while (!io_in_ready && n < 50) begin @(posedge clock); #1; n++; end
        io_out_ready = 1'b0;
        io_input1    = 32'h40200000;
        io_unsigned  = 1'b0;
        io_rmm       = 3'd4;
        io_in_valid  = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        n = 0;
        while (!io_out_valid && n < 200) begin @(posedge clock); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check($sformatf("hold%0d result", i), io_result, 32'd3);
            check($sformatf("hold%0d ctl", i),
                  32'({io_out_valid, io_in_ready, io_flag_nv, io_flag_nx}), 32'b1001);
        end
        io_out_ready = 1'b1;
        @(posedge clock); #1;
        check("release ctl", 32'({io_out_valid, io_in_ready}), 32'b01);

        // Reset in the middle of a long right shift
        io_input1   = 32'h40490FDB;
        io_unsigned = 1'b0;
        io_rmm      = 3'd0;
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("midshift busy", 32'(io_in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("midshift reset ctl", 32'({io_out_valid, io_in_ready}), 32'b01);
        check("midshift reset result", io_result, 32'h0);
        ref_model(32'h3FC00000, 1'b0, 3'd0, m_res, m_nv, m_nx, m_ill, m_lat);
        run_case("post_reset", 32'h3FC00000, 1'b0, 3'd0, 32'd2, 1'b0, 1'b1, 1'b0, m_lat);

        // Random operands, biased toward the interesting exponent window
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                op = {1'($urandom_range(0, 1)), 8'($urandom_range(115, 162)), 23'($urandom)};
            end else begin
                op = $urandom;
            end
            r   = int'($urandom_range(0, 15));
            rm  = (r < 13) ? 3'(r % 5) : 3'(5 + (r % 3));
            uns = 1'($urandom_range(0, 1));
            ref_model(op, uns, rm, m_res, m_nv, m_nx, m_ill, m_lat);
            run_case($sformatf("rnd%0d op=%h u=%0d rm=%0d", i, op, uns, rm),
                     op, uns, rm, m_res, m_nv, m_nx, m_ill, m_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fcvt_f2i.md
Name: fcvt_f2i

Overview:
- Multi-cycle converter from single-precision float to 32-bit integer: FCVT.W.S (signed) and FCVT.WU.S (unsigned).
- Works in the decode direction of the FPU datapath. The FALU packs sign, exponent and fraction into IEEE-754 words; this block unpacks a word back to an integer.
- Sits beside the FALU in the rv32 FPU execute stage. Uses a valid/ready handshake on both sides and an iterative alignment shifter.

Parameters:
- SHIFT_PER_CYCLE, 1, bit positions the alignment shifter moves per cycle. Legal values: 1, 2, 4.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- io_in_valid  in  1  request valid.
- io_in_ready  out  1  block can accept a request.
- io_input1  in  32  IEEE-754 single operand.
- io_unsigned  in  1  1 = FCVT.WU.S, 0 = FCVT.W.S.
- io_rmm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts result.
- io_result  out  32  integer result.
- io_flag_nv  out  1  invalid flag.
- io_flag_nx  out  1  inexact flag.
- io_illegal_rm  out  1  io_rmm was 5..7 when the request was accepted.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; io_out_valid=0, io_result=0, all flags 0, io_in_ready=1.
- Reset mid-operation abandons the conversion; the cycle after reset the block is IDLE.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: io_in_ready=1. A transfer occurs when io_in_valid=1.
- On a transfer the block latches sign s, exponent e, mantissa m={e!=0,frac}, unsigned and rm, then classifies the operand:
  - NaN (e=255, frac!=0), infinity (e=255), or e>=159 (|x|>=2^32): go to ROUND with a special-case mark.
  - e>=150: left shift by L=e-150 (at most 8). The working register is mag[32:0].
  - 126<=e<150: right shift by R=150-e (1..24). Bits shifted out feed guard g (last bit out) and sticky st (OR of all earlier bits out).
  - e<126 (|x|<0.5), including zero and denormals: mag=0, g=0, st=(e!=0 || frac!=0). Go straight to ROUND.
  - rm 5..7: io_illegal_rm=1. Result 0, nv=0, nx=0. Go to DONE directly.
- SHIFT: each cycle moves min(SHIFT_PER_CYCLE, remaining) positions. Exits to ROUND when remaining reaches 0. Shift count N=L or R, and SHIFT lasts ceil(N/SHIFT_PER_CYCLE) cycles.
- ROUND (one cycle): compute increment inc from guard g and sticky st:
  - RNE: g&(st|mag[0]).
  - RTZ: 0.
  - RDN: (g|st)&s.
  - RUP: (g|st)&~s.
  - RMM: g.
- ROUND then forms mag'=mag+inc (33 bits) and range-checks it:
  - Signed, s=0: mag'>2^31-1 → 0x7FFFFFFF, nv=1.
  - Signed, s=1: mag'>2^31 → 0x80000000, nv=1. Otherwise the result is the two's complement of mag'.
  - Unsigned, s=0: mag'>2^32-1 → 0xFFFFFFFF, nv=1.
  - Unsigned, s=1: mag'!=0 → 0x00000000, nv=1. If mag'=0 → 0, nv=0.
  - NaN: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, nv=1.
  - +inf/large positive: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, nv=1.
  - -inf/large negative: signed 0x80000000, unsigned 0, nv=1.
  - nx = (g|st) & ~nv.
- DONE: io_out_valid=1. io_result and flags stay stable until io_out_ready=1, then the block returns to IDLE.
  - io_in_ready=0 in SHIFT, ROUND and DONE; there is no overlap with the next request.
- Latency, accept edge to io_out_valid: ceil(N/SHIFT_PER_CYCLE)+2 cycles. Special/tiny cases take 2 cycles; illegal rm takes 1 cycle.
- Outputs are registered. io_result and flags hold their last value while IDLE.

Decomposition:
- Shared package fpu_pkg holds:
  - rounding-mode constants RNE/RTZ/RDN/RUP/RMM.
  - FP32 field widths; EXP_BIAS=127; MANT_W=24.
  - canonical integer saturation constants 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF.
  - a round_inc function (rm, sign, lsb, g, st).
- One natural sub-module: fcvt_align_shifter. It holds mag/g/st, performs the per-cycle shift, and collects sticky. The FSM and the round/range check stay in fcvt_f2i.

Test Plan:
- 0x40490FDB (3.14159), signed, RNE → result 3, nx=1, nv=0. N=22, so io_out_valid rises 24 cycles after accept with SHIFT_PER_CYCLE=1, and 8 cycles with SHIFT_PER_CYCLE=4.
- Rounding on 0x3FC00000 (1.5): RNE→2, RTZ→1, RDN→1, RUP→2, RMM→2. On 0x40200000 (2.5): RNE→2, RMM→3. On 0xC0200000 (-2.5): RDN→0xFFFFFFFD, RUP→0xFFFFFFFE. All nx=1.
- 0x4F000000 (2^31): signed → 0x7FFFFFFF, nv=1; unsigned → 0x80000000, no flags. 0xCF000000 signed → 0x80000000, no flags.
- Special operands:
  - 0x7FC00000 (NaN) signed → 0x7FFFFFFF, nv=1.
  - 0xFF800000 (-inf) unsigned → 0, nv=1.
  - 0x00000000 → 0, no flags.
  - 0xBE99999A (-0.3) unsigned RTZ → 0, nx=1, nv=0.
- Handshake and illegal rm:
  - Hold io_out_ready=0 for 5 cycles in DONE → io_result and flags stable, io_in_ready=0.
  - io_rmm=5 → io_illegal_rm=1, result 0 after 1 cycle.
- Pull reset low during SHIFT → next cycle io_out_valid=0, io_in_ready=1. A fresh request then converts correctly.
